pio_irq_servicer: RTL

PIO_IRQ_SERVICER -- requirements
Module: pio_irq_servicer

---
 rtl/pio_irq_servicer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/pio_irq_servicer.sv
// pio_irq_servicer
//   Services a 4-bit button PIO over a simple Avalon-MM master port. After
//   reset it programs the PIO irq_mask. Each interrupt is serviced by reading
//   edge_capture, clearing exactly the bits that were read (write-1-to-clear),
//   and presenting them as one event on a valid/ready stream. The host can
//   rewrite the mask at any time through mask_in/mask_load.
//
// Ports
//   clk, reset       : clock, asynchronous active-high reset
//   avm_*            : master port to the PIO (address, chipselect, write_n,
//                      writedata, readdata, irq)
//   mask_in/load     : new irq_mask value and its one-cycle load strobe
//   event_valid/bits : captured edge event, held until event_ready
//   event_ready      : consumer accepts the current event
//   event_count      : number of accepted events (wraps)
//   busy             : high whenever the servicer is not idle
module pio_irq_servicer #(
    parameter logic [3:0] MASK_INIT = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_irq,
    input  logic [3:0]  mask_in,
    input  logic        mask_load,
    output logic        event_valid,
    output logic [3:0]  event_bits,
    input  logic        event_ready,
    output logic [15:0] event_count,
    output logic        busy
);

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NBITS  = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [ADDR_W-1:0] ADDR_DATA = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_EDGE = ADDR_W'(3);

    typedef enum logic [2:0] {
        S_INIT_MASK,
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_CLR,
        S_SETTLE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Next values of the registered bus outputs
    logic              cs_nxt;
    logic              wn_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wd_nxt;

    logic              mask_clr_c;   // IDLE is issuing the pending mask write
    logic              cap_load_c;   // RD_DATA is sampling edge_capture
    logic              ev_set_c;     // leaving CLR publishes the event

    logic [NBITS-1:0]  pending_mask;
    logic              mask_pend;
    logic [NBITS-1:0]  cap_q;
    logic [NBITS-1:0]  rd_cap;

    // Only the four button bits of the PIO are meaningful
    logic              unused_readdata;

    assign rd_cap          = avm_readdata[NBITS-1:0];
    assign unused_readdata = ^avm_readdata[DATA_W-1:NBITS];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT_MASK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next bus access. The access chosen here is registered,
    // so it appears on the bus during the cycle after the deciding edge.
    always_comb begin
        state_nxt  = state;
        cs_nxt     = 1'b0;
        wn_nxt     = 1'b1;
        addr_nxt   = ADDR_DATA;
        wd_nxt     = '0;
        mask_clr_c = 1'b0;
        cap_load_c = 1'b0;
        ev_set_c   = 1'b0;

        case (state)
            S_INIT_MASK: begin
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
                addr_nxt  = ADDR_MASK;
                wd_nxt    = DATA_W'(MASK_INIT);
                state_nxt = S_IDLE;
            end

            S_IDLE: begin
                // Wait for the previous access to finish so accesses are
                // always separated by an idle bus cycle.
                if (!avm_chipselect) begin
                    if (mask_pend) begin
                        cs_nxt     = 1'b1;
                        wn_nxt     = 1'b0;
                        addr_nxt   = ADDR_MASK;
                        wd_nxt     = DATA_W'(pending_mask);
                        mask_clr_c = 1'b1;
                    end else if (avm_irq && !event_valid) begin
                        // An unconsumed event blocks reading, so new edges
                        // keep accumulating inside the PIO.
                        cs_nxt    = 1'b1;
                        wn_nxt    = 1'b1;
                        addr_nxt  = ADDR_EDGE;
                        state_nxt = S_RD_ADDR;
                    end
                end
            end

            S_RD_ADDR: begin
                state_nxt = S_RD_DATA;
            end

            S_RD_DATA: begin
                cap_load_c = 1'b1;
                if (rd_cap == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    // Clear only the bits just read; later edges stay captured
                    cs_nxt    = 1'b1;
                    wn_nxt    = 1'b0;
                    addr_nxt  = ADDR_EDGE;
                    wd_nxt    = DATA_W'(rd_cap);
                    state_nxt = S_CLR;
                end
            end

            S_CLR: begin
                ev_set_c  = 1'b1;
                state_nxt = S_SETTLE;
            end

            S_SETTLE: begin
                // One quiet cycle lets the PIO drop its irq after the clear
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_INIT_MASK;
            end
        endcase
    end

    // Registered bus outputs and busy flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= ADDR_DATA;
            avm_writedata  <= '0;
            busy           <= 1'b1;
        end else begin
            avm_chipselect <= cs_nxt;
            avm_write_n    <= wn_nxt;
            avm_address    <= addr_nxt;
            avm_writedata  <= wd_nxt;
            busy           <= (state_nxt != S_IDLE);
        end
    end

    // Mask rewrite request; a new load wins over the clear of the old one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_mask <= '0;
            mask_pend    <= 1'b0;
        end else if (mask_load) begin
            pending_mask <= mask_in;
            mask_pend    <= 1'b1;
        end else if (mask_clr_c) begin
            mask_pend    <= 1'b0;
        end
    end

    // Captured edges held for the event publish at the end of CLR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_q <= '0;
        end else if (cap_load_c) begin
            cap_q <= rd_cap;
        end
    end

    // Event stream: valid/ready handshake and accepted-event counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_valid <= 1'b0;
            event_bits  <= '0;
            event_count <= '0;
        end else begin
            if (event_valid && event_ready) begin
                event_valid <= 1'b0;
                event_count <= CNT_W'(event_count + CNT_W'(1));
            end
            if (ev_set_c) begin
                event_valid <= 1'b1;
                event_bits  <= cap_q;
            end
        end
    end

endmodule
